// File: rtl/sipo.sv
// Serial-in, parallel-out shift register.
// One bit is captured per rising edge; the register contents are the parallel word.
module sipo #(
    parameter int unsigned     WIDTH       = 4,
    parameter bit              SHIFT_LEFT  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next word: new bit enters at the LSB (left shift) or the MSB (right shift).
    always_comb begin
        shreg_d = shreg_q;
        if (SHIFT_LEFT) begin
            shreg_d = {shreg_q[WIDTH-2:0], serial_in};
        end else begin
            shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
        end
    end

    // Synchronous reset discards any partially assembled word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= RESET_VALUE;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign parallel_out = shreg_q;

endmodule

// File: tb/tb_sipo.sv
// Directed vector bench for sipo: left-shift, right-shift and a 5-bit
// instance with a non-zero reset value, all driven from the same inputs.
module tb_sipo;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [3:0] pout_l;
    logic [3:0] pout_r;
    logic [4:0] pout_w;

    int total;
    int bad;

    sipo #(.WIDTH(4), .SHIFT_LEFT(1'b1), .RESET_VALUE(4'b0000)) dut_l (
        .clk(clk), .rst(rst), .serial_in(serial_in), .parallel_out(pout_l)
    );

    sipo #(.WIDTH(4), .SHIFT_LEFT(1'b0), .RESET_VALUE(4'b0000)) dut_r (
        .clk(clk), .rst(rst), .serial_in(serial_in), .parallel_out(pout_r)
    );

    sipo #(.WIDTH(5), .SHIFT_LEFT(1'b1), .RESET_VALUE(5'b10110)) dut_w (
        .clk(clk), .rst(rst), .serial_in(serial_in), .parallel_out(pout_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sin;
        logic [3:0] exp_l;
        logic [3:0] exp_r;
        logic [4:0] exp_w;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] el,
                             input logic [3:0] er, input logic [4:0] ew);
        check({tag, " left"},  8'(pout_l), 8'(el));
        check({tag, " right"}, 8'(pout_r), 8'(er));
        check({tag, " w5"},    8'(pout_w), 8'(ew));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //             rst   sin   left     right    w5
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 5'b10110};
        vecs[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 5'b10110};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 5'b01100};
        vecs[3]  = '{1'b0, 1'b1, 4'b0001, 4'b1000, 5'b11001};
        vecs[4]  = '{1'b0, 1'b0, 4'b0010, 4'b0100, 5'b10010};
        vecs[5]  = '{1'b0, 1'b0, 4'b0100, 4'b0010, 5'b00100};
        vecs[6]  = '{1'b0, 1'b1, 4'b1001, 4'b1001, 5'b01001};
        vecs[7]  = '{1'b0, 1'b0, 4'b0010, 4'b0100, 5'b10010};
        vecs[8]  = '{1'b0, 1'b0, 4'b0100, 4'b0010, 5'b00100};
        vecs[9]  = '{1'b0, 1'b0, 4'b1000, 4'b0001, 5'b01000};
        vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 5'b10000};
        vecs[11] = '{1'b0, 1'b1, 4'b0001, 4'b1000, 5'b00001};
        vecs[12] = '{1'b0, 1'b1, 4'b0011, 4'b1100, 5'b00011};
        vecs[13] = '{1'b0, 1'b1, 4'b0111, 4'b1110, 5'b00111};
        vecs[14] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 5'b01111};
        vecs[15] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 5'b11111};
        vecs[16] = '{1'b0, 1'b0, 4'b1110, 4'b0111, 5'b11110};
        vecs[17] = '{1'b0, 1'b1, 4'b1101, 4'b1011, 5'b11101};
        vecs[18] = '{1'b0, 1'b1, 4'b1011, 4'b1101, 5'b11011};
        vecs[19] = '{1'b0, 1'b0, 4'b0110, 4'b0110, 5'b10110};
        vecs[20] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 5'b10110};
        vecs[21] = '{1'b0, 1'b1, 4'b0001, 4'b1000, 5'b01101};

        // Inputs change on the falling edge, outputs are sampled 1 after the rising edge.
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            rst       = vecs[i].rst;
            serial_in = vecs[i].sin;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_w);
        end

        // rst raised between edges must not act before the next rising edge.
        @(negedge clk);
        rst       = 1'b1;
        serial_in = 1'b0;
        #2;
        check_all("rst_pre_edge", 4'b0001, 4'b1000, 5'b01101);
        serial_in = 1'b1;
        #1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_edge", 4'b0000, 4'b0000, 5'b10110);

        // Glitches on serial_in between edges; only the value at the edge counts.
        @(negedge clk);
        rst       = 1'b0;
        serial_in = 1'b0;
        #1 serial_in = 1'b1;
        #1 serial_in = 1'b0;
        #1 serial_in = 1'b1;
        check_all("between_edges", 4'b0000, 4'b0000, 5'b10110);
        @(posedge clk);
        #1;
        check_all("glitch_one", 4'b0001, 4'b1000, 5'b01101);

        @(negedge clk);
        serial_in = 1'b1;
        #2 serial_in = 1'b0;
        #1 serial_in = 1'b1;
        #1 serial_in = 1'b0;
        @(posedge clk);
        #1;
        check_all("glitch_zero", 4'b0010, 4'b0100, 5'b11010);

        // Output must hold steady right up to the next edge.
        #3;
        check_all("hold_late", 4'b0010, 4'b0100, 5'b11010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
